// File: rtl/irq_ctrl4.sv
// irq_ctrl4: 4-line edge-detecting interrupt controller with fixed priority and ack/eoi handshake
module irq_ctrl4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] irq,
  input  logic [3:0] mask,
  input  logic       ack,
  input  logic       eoi,
  output logic       irq_valid,
  output logic [2:0] irq_code,
  output logic       busy,
  output logic [3:0] pend
);
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] REQ  = 2'b01;
  localparam logic [1:0] SERV = 2'b10;
  logic [1:0] state;
  logic [3:0] irq_d, rise, pm, clr;
  logic [2:0] win;
  assign rise = irq & ~irq_d;
  assign pm = pend & ~mask;
  assign win = pm[3] ? 3'd3 : pm[2] ? 3'd2 : pm[1] ? 3'd1 : 3'd0;
  assign clr = (state == REQ && ack) ? 4'b0001 << irq_code[1:0] : 4'b0000;
  // state encoding makes both outputs direct flop bits
  assign irq_valid = state[0];
  assign busy = state[1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      irq_d <= 4'b0000;
      pend <= 4'b0000;
      irq_code <= 3'b000;
    end else begin
      irq_d <= irq;
      pend <= (pend & ~clr) | rise;
      case (state)
        IDLE: if (|pm) begin
          state <= REQ;
          irq_code <= win;
        end
        REQ: if (ack) state <= SERV;
        SERV: if (eoi) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
